// File: rtl/rf_writeback_pkg.sv
// rtl/rf_writeback_pkg.sv - shared widths and pending-queue entry type for the write-back arbiter
package rf_writeback_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;
  localparam int DATA_W    = 32;

  typedef struct packed {
    logic                 live;
    logic [REG_IDX_W-1:0] rd;
    logic [DATA_W-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/wb_pending_queue.sv
// rtl/wb_pending_queue.sv - circular buffer of memory results with kill-by-rd and youngest-match lookup
module wb_pending_queue
  import rf_writeback_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  wb_entry_t            push_entry,
  input  logic                 pop,
  input  logic                 kill,
  input  logic [REG_IDX_W-1:0] kill_rd,
  output wb_entry_t            head,
  output logic                 empty,
  output logic                 ready,
  input  logic [REG_IDX_W-1:0] lookup_rs,
  output logic                 lookup_hit,
  output logic [DATA_W-1:0]    lookup_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t      slots [DEPTH];
  logic [PW-1:0]  head_ptr;
  logic [PW-1:0]  tail_ptr;
  logic [CW-1:0]  count;
  logic [PW-1:0]  idx;

  assign head  = slots[head_ptr];
  assign empty = (count == '0);
  assign ready = (count < CW'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else begin
      // The slot being written by push is free, so killing first never races with it.
      if (kill) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (slots[i].rd == kill_rd) slots[i].live <= 1'b0;
        end
      end
      if (push) begin
        slots[tail_ptr] <= push_entry;
        tail_ptr        <= tail_ptr + 1'b1;
      end
      if (pop) head_ptr <= head_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Walk oldest to youngest so the last match seen is the newest value.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    idx         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_ptr + PW'(i);
      if ((CW'(i) < count) && slots[idx].live && (slots[idx].rd == lookup_rs)) begin
        lookup_hit  = 1'b1;
        lookup_data = slots[idx].data;
      end
    end
  end

endmodule

// File: rtl/rf_writeback.sv
// rtl/rf_writeback.sv - merges ALU and queued memory results onto the single register-file write port
module rf_writeback
  import rf_writeback_pkg::*;
#(
  parameter int N     = DATA_W,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [N-1:0]         alu_data,
  input  logic                 mem_valid,
  input  logic [REG_IDX_W-1:0] mem_rd,
  input  logic [N-1:0]         mem_data,
  output logic                 mem_ready,
  output logic                 rf_we,
  output logic [REG_IDX_W-1:0] rf_wr,
  output logic [N-1:0]         rf_wd,
  input  logic [REG_IDX_W-1:0] fwd_rs,
  output logic                 fwd_hit,
  output logic [N-1:0]         fwd_data
);

  logic      alu_sel;
  logic      q_push;
  logic      q_pop;
  logic      q_empty;
  logic      q_hit;
  logic [N-1:0] q_data;
  wb_entry_t push_entry;
  wb_entry_t head;

  assign alu_sel = alu_valid && (alu_rd != '0);
  assign q_pop   = !alu_sel && !q_empty;
  // rd=0 results complete the handshake but are dropped here.
  assign q_push  = mem_valid && mem_ready && (mem_rd != '0);

  // A same-cycle ALU write to the same rd is the newer value.
  assign push_entry = '{live: !(alu_sel && (alu_rd == mem_rd)), rd: mem_rd, data: mem_data};

  wb_pending_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (q_push),
    .push_entry (push_entry),
    .pop        (q_pop),
    .kill       (alu_sel),
    .kill_rd    (alu_rd),
    .head       (head),
    .empty      (q_empty),
    .ready      (mem_ready),
    .lookup_rs  (fwd_rs),
    .lookup_hit (q_hit),
    .lookup_data(q_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_wr <= '0;
      rf_wd <= '0;
    end else if (alu_sel) begin
      rf_we <= 1'b1;
      rf_wr <= alu_rd;
      rf_wd <= alu_data;
    end else if (!q_empty) begin
      rf_we <= head.live;
      rf_wr <= head.rd;
      rf_wd <= head.data;
    end else begin
      rf_we <= 1'b0;
    end
  end

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_rs != '0) begin
      if (q_hit) begin
        fwd_hit  = 1'b1;
        fwd_data = q_data;
      end else if (rf_we && (rf_wr == fwd_rs)) begin
        fwd_hit  = 1'b1;
        fwd_data = rf_wd;
      end
    end
  end

endmodule

// File: tb/tb_rf_writeback.sv
// tb/tb_rf_writeback.sv - directed checks of rf_writeback arbitration, queueing, kill and forwarding
module tb_rf_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_data = '0;
  logic        mem_ready;
  logic        rf_we;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wd;
  logic [4:0]  fwd_rs = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  int n_cmp  = 0;
  int n_fail = 0;

  rf_writeback #(.N(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd),
    .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    fwd_rs = 5'd5;
    #2;
    n_cmp++; if ({rf_we, rf_wr, rf_wd} !== 38'd0) begin n_fail++; $display("FAIL reset_out: got %0b/%0d/%h want 0/0/0", rf_we, rf_wr, rf_wd); end
    n_cmp++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", mem_ready); end
    n_cmp++; if ({fwd_hit, fwd_data} !== 33'd0) begin n_fail++; $display("FAIL reset_fwd: got %b/%h want 0/0", fwd_hit, fwd_data); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_alu();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hAAAA_0001;
    step();
    alu_valid = 1'b0;
    #1;
    n_cmp++; if ({rf_we, rf_wr, rf_wd} !== {1'b1, 5'd5, 32'hAAAA_0001}) begin n_fail++; $display("FAIL alu_write: got %0b/%0d/%h want 1/5/aaaa0001", rf_we, rf_wr, rf_wd); end
    n_cmp++; if ({fwd_hit, fwd_data} !== {1'b1, 32'hAAAA_0001}) begin n_fail++; $display("FAIL alu_fwd: got %b/%h want 1/aaaa0001", fwd_hit, fwd_data); end
    step();
    n_cmp++; if ({rf_we, rf_wr} !== {1'b0, 5'd5}) begin n_fail++; $display("FAIL alu_idle: got %0b/%0d want 0/5", rf_we, rf_wr); end
    n_cmp++; if (fwd_hit !== 1'b0) begin n_fail++; $display("FAIL alu_fwd_gone: got %b want 0", fwd_hit); end
  endtask

  task automatic test_mem_latency();
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h1234; fwd_rs = 5'd7;
    #1;
    n_cmp++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL mem_ready_idle: got %b want 1", mem_ready); end
    step();
    mem_valid = 1'b0;
    #1;
    n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mem_early: got rf_we=%b want 0", rf_we); end
    n_cmp++; if ({fwd_hit, fwd_data} !== {1'b1, 32'h1234}) begin n_fail++; $display("FAIL mem_fwd_queued: got %b/%h want 1/1234", fwd_hit, fwd_data); end
    step();
    n_cmp++; if ({rf_we, rf_wr, rf_wd} !== {1'b1, 5'd7, 32'h1234}) begin n_fail++; $display("FAIL mem_write: got %0b/%0d/%h want 1/7/1234", rf_we, rf_wr, rf_wd); end
    n_cmp++; if ({fwd_hit, fwd_data} !== {1'b1, 32'h1234}) begin n_fail++; $display("FAIL mem_fwd_outreg: got %b/%h want 1/1234", fwd_hit, fwd_data); end
    step();
    n_cmp++; if ({rf_we, fwd_hit} !== 2'b00) begin n_fail++; $display("FAIL mem_done: got we=%b hit=%b want 0/0", rf_we, fwd_hit); end
  endtask

  task automatic test_fill();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h300;
    mem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_rd = 5'(10 + i); mem_data = 32'h100 + i;
      #1;
      n_cmp++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_%0d: got %b want 1", i, mem_ready); end
      step();
    end
    mem_rd = 5'd14; mem_data = 32'h104; fwd_rs = 5'd12;
    #1;
    n_cmp++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: got %b want 0", mem_ready); end
    n_cmp++; if ({fwd_hit, fwd_data} !== {1'b1, 32'h102}) begin n_fail++; $display("FAIL fill_fwd: got %b/%h want 1/102", fwd_hit, fwd_data); end
    step(); step();
    n_cmp++; if ({mem_ready, rf_we, rf_wr} !== {1'b0, 1'b1, 5'd3}) begin n_fail++; $display("FAIL fill_stall: got rdy=%b we=%b wr=%0d want 0/1/3", mem_ready, rf_we, rf_wr); end
    alu_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      step();
      if (j == 1) mem_valid = 1'b0;
      n_cmp++; if ({rf_we, rf_wr, rf_wd} !== {1'b1, 5'(10 + j), 32'h100 + j}) begin n_fail++; $display("FAIL drain_%0d: got %0b/%0d/%h want 1/%0d/%h", j, rf_we, rf_wr, rf_wd, 10 + j, 32'h100 + j); end
    end
    step();
    n_cmp++; if ({rf_we, mem_ready} !== 2'b01) begin n_fail++; $display("FAIL drain_end: got we=%b rdy=%b want 0/1", rf_we, mem_ready); end
  endtask

  task automatic test_kill();
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h11; fwd_rs = 5'd9;
    step();
    mem_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h22;
    step();
    alu_valid = 1'b0;
    #1;
    n_cmp++; if ({rf_we, rf_wr, rf_wd} !== {1'b1, 5'd9, 32'h22}) begin n_fail++; $display("FAIL kill_alu: got %0b/%0d/%h want 1/9/22", rf_we, rf_wr, rf_wd); end
    n_cmp++; if ({fwd_hit, fwd_data} !== {1'b1, 32'h22}) begin n_fail++; $display("FAIL kill_fwd: got %b/%h want 1/22", fwd_hit, fwd_data); end
    step();
    n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL kill_pop: got rf_we=%b want 0", rf_we); end
    n_cmp++; if (fwd_hit !== 1'b0) begin n_fail++; $display("FAIL kill_fwd_after: got %b want 0", fwd_hit); end
    // same-cycle collision: queued copy enters dead
    mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'h66;
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h77; fwd_rs = 5'd6;
    step();
    mem_valid = 1'b0; alu_valid = 1'b0;
    #1;
    n_cmp++; if ({rf_we, rf_wr, rf_wd, fwd_hit, fwd_data} !== {1'b1, 5'd6, 32'h77, 1'b1, 32'h77}) begin n_fail++; $display("FAIL same_cycle_kill: got %0b/%0d/%h fwd %b/%h want 1/6/77 fwd 1/77", rf_we, rf_wr, rf_wd, fwd_hit, fwd_data); end
    step();
    n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL same_cycle_pop: got rf_we=%b want 0", rf_we); end
    step();
  endtask

  task automatic test_rd_zero();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hBEEF; fwd_rs = 5'd0;
    #1;
    n_cmp++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready: got %b want 1", mem_ready); end
    step();
    alu_valid = 1'b0; mem_valid = 1'b0;
    #1;
    n_cmp++; if ({rf_we, fwd_hit} !== 2'b00) begin n_fail++; $display("FAIL zero_write: got we=%b hit=%b want 0/0", rf_we, fwd_hit); end
    step();
    n_cmp++; if ({rf_we, mem_ready} !== 2'b01) begin n_fail++; $display("FAIL zero_count: got we=%b rdy=%b want 0/1", rf_we, mem_ready); end
  endtask

  task automatic test_reset_mid();
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
    mem_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_rd = 5'(20 + i); mem_data = 32'h120 + i;
      step();
    end
    alu_valid = 1'b0; mem_valid = 1'b0; fwd_rs = 5'd21;
    #1;
    n_cmp++; if ({fwd_hit, fwd_data} !== {1'b1, 32'h121}) begin n_fail++; $display("FAIL mid_queued: got %b/%h want 1/121", fwd_hit, fwd_data); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({rf_we, rf_wr, rf_wd} !== 38'd0) begin n_fail++; $display("FAIL mid_reset_out: got %0b/%0d/%h want 0/0/0", rf_we, rf_wr, rf_wd); end
    n_cmp++; if ({mem_ready, fwd_hit, fwd_data} !== {1'b1, 1'b0, 32'h0}) begin n_fail++; $display("FAIL mid_reset_q: got rdy=%b hit=%b data=%h want 1/0/0", mem_ready, fwd_hit, fwd_data); end
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mid_no_write_%0d: got rf_we=%b want 0", k, rf_we); end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem_latency();
    test_fill();
    test_kill();
    test_rd_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
